// File: rtl/pe_pkg.sv
// Shared types and constants for the pair-sum scheduler and its operand buffer.
package pe_pkg;

  localparam int          FP_W    = 32;
  localparam logic [31:0] FP_ZERO = 32'h0000_0000;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_PAIR,
    WAIT_PAIR,
    ISSUE_ACC,
    WAIT_ACC,
    DONE
  } state_e;

endpackage

// File: rtl/pe_operand_buf.sv
// N-entry A/B operand buffer: one write port and one read port, no control logic.
module pe_operand_buf
  import pe_pkg::*;
#(
  parameter int N  = 2,
  parameter int CW = $clog2(N + 1)
) (
  input  logic            clk,
  input  logic            wr_en,
  input  logic [CW-1:0]   wr_idx,
  input  logic [FP_W-1:0] wr_a,
  input  logic [FP_W-1:0] wr_b,
  input  logic [CW-1:0]   rd_idx,
  output logic [FP_W-1:0] rd_a,
  output logic [FP_W-1:0] rd_b
);

  localparam int AW = (N > 1) ? $clog2(N) : 1;

  logic [FP_W-1:0] a_mem [N];
  logic [FP_W-1:0] b_mem [N];

  // NOTE: storage is deliberately not reset; every entry is written before a run can start.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      a_mem[wr_idx[AW-1:0]] <= wr_a;
      b_mem[wr_idx[AW-1:0]] <= wr_b;
    end
  end

  assign rd_a = a_mem[rd_idx[AW-1:0]];
  assign rd_b = b_mem[rd_idx[AW-1:0]];

endmodule

// File: rtl/pe_pair_sum_sched.sv
// Shares one external FP adder to compute sum(A[i] + B[i]): a pair-sum then an
// accumulate per element, one outstanding request at a time.
module pe_pair_sum_sched
  import pe_pkg::*;
#(
  parameter int N  = 2,
  parameter int CW = $clog2(N + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_valid,
  input  logic [FP_W-1:0] load_a,
  input  logic [FP_W-1:0] load_b,
  output logic            load_ready,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [FP_W-1:0] result,
  output logic            fp_req,
  output logic [FP_W-1:0] fp_a,
  output logic [FP_W-1:0] fp_b,
  input  logic            fp_ack,
  input  logic [FP_W-1:0] fp_sum
);

  localparam logic [CW-1:0] FULL = CW'(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   load_cnt_q, load_cnt_d;
  logic [CW-1:0]   idx_q, idx_d;
  logic [FP_W-1:0] acc_q, acc_d;
  logic [FP_W-1:0] s_q, s_d;
  logic [FP_W-1:0] result_q, result_d;

  logic            buf_we;
  logic            start_ok;
  logic [FP_W-1:0] buf_a, buf_b;

  pe_operand_buf #(.N(N), .CW(CW)) u_buf (
    .clk    (clk),
    .wr_en  (buf_we),
    .wr_idx (load_cnt_q),
    .wr_a   (load_a),
    .wr_b   (load_b),
    .rd_idx (idx_q),
    .rd_a   (buf_a),
    .rd_b   (buf_b)
  );

  // Handshake outputs are forced low while reset is asserted.
  assign load_ready = !rst && (state_q == IDLE) && (load_cnt_q < FULL);
  assign buf_we     = load_valid && load_ready;
  assign start_ok   = !rst && (state_q == IDLE) && start && (load_cnt_q == FULL);
  assign busy       = !rst && (state_q != IDLE);
  assign done       = !rst && (state_q == DONE);
  assign fp_req     = !rst && ((state_q == ISSUE_PAIR) || (state_q == ISSUE_ACC));
  assign result     = result_q;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    s_d        = s_q;
    result_d   = result_q;
    fp_a       = FP_ZERO;
    fp_b       = FP_ZERO;

    case (state_q)
      IDLE: begin
        if (buf_we) load_cnt_d = load_cnt_q + CW'(1);
        if (start_ok) begin
          acc_d   = FP_ZERO;
          idx_d   = '0;
          state_d = ISSUE_PAIR;
        end
      end
      ISSUE_PAIR, WAIT_PAIR: begin
        fp_a = buf_a;
        fp_b = buf_b;
        if (state_q == ISSUE_PAIR) begin
          state_d = WAIT_PAIR;
        end else if (fp_ack) begin
          s_d     = fp_sum;
          state_d = ISSUE_ACC;
        end
      end
      ISSUE_ACC, WAIT_ACC: begin
        fp_a = acc_q;
        fp_b = s_q;
        if (state_q == ISSUE_ACC) begin
          state_d = WAIT_ACC;
        end else if (fp_ack) begin
          acc_d = fp_sum;
          if (idx_q == LAST) begin
            // Capture here so result already equals acc during the done pulse.
            result_d = fp_sum;
            state_d  = DONE;
          end else begin
            idx_d   = idx_q + CW'(1);
            state_d = ISSUE_PAIR;
          end
        end
      end
      DONE: begin
        load_cnt_d = '0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (rst) begin
      fp_a = FP_ZERO;
      fp_b = FP_ZERO;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      load_cnt_q <= '0;
      idx_q      <= '0;
      acc_q      <= FP_ZERO;
      s_q        <= FP_ZERO;
      result_q   <= FP_ZERO;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      s_q        <= s_d;
      result_q   <= result_d;
    end
  end

endmodule

// File: tb/tb_pe_pair_sum_sched.sv
// Scoreboard bench for pe_pair_sum_sched with a latency-configurable adder model.
module tb_pe_pair_sum_sched;

  localparam int N  = 2;
  localparam int CW = $clog2(N + 1);

  logic        clk = 1'b0;
  logic        rst;
  logic        load_valid;
  logic [31:0] load_a, load_b;
  logic        load_ready;
  logic        start;
  logic        busy, done;
  logic [31:0] result;
  logic        fp_req;
  logic [31:0] fp_a, fp_b;
  logic        fp_ack;
  logic [31:0] fp_sum;
  logic        model_ack, stray_ack;

  assign fp_ack = model_ack | stray_ack;

  pe_pair_sum_sched #(.N(N), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_a     (load_a),
    .load_b     (load_b),
    .load_ready (load_ready),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .fp_req     (fp_req),
    .fp_a       (fp_a),
    .fp_b       (fp_b),
    .fp_ack     (fp_ack),
    .fp_sum     (fp_sum)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
  } req_t;

  req_t        req_q[$];
  logic [31:0] res_q[$];

  int lat          = 1;
  int cyc          = 0;
  int start_cyc    = 0;
  int exp_done_cyc = 0;
  int req_count    = 0;
  bit done_seen    = 1'b0;

  always @(posedge clk) cyc++;

  // Adder model: known single-precision sums for the test vectors.
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3FC00000, 32'hC0400000}: fadd = 32'hBFC00000;
      {32'h00000000, 32'hBFC00000}: fadd = 32'hBFC00000;
      {32'hC0300000, 32'h40000000}: fadd = 32'hBF400000;
      {32'hBFC00000, 32'hBF400000}: fadd = 32'hC0100000;
      default:                      fadd = a + b;
    endcase
  endfunction

  int          pend = 0;
  logic [31:0] cap_a, cap_b;
  logic        prev_req = 1'b0;
  req_t        exp_req;

  // Adder model and output monitor share the falling edge.
  always @(negedge clk) begin
    model_ack = 1'b0;
    if (pend > 0) begin
      if (busy && !rst) begin
        check("fp_a_stable", fp_a, cap_a);
        check("fp_b_stable", fp_b, cap_b);
      end
      pend--;
      if (pend == 0) begin
        model_ack = 1'b1;
        fp_sum    = fadd(cap_a, cap_b);
      end
    end
    if (fp_req) begin
      req_count++;
      check("fp_req_gap", {31'b0, prev_req}, 32'd0);
      if (req_q.size() == 0) begin
        check("fp_req_unexpected", 32'd1, 32'd0);
      end else begin
        exp_req = req_q.pop_front();
        check("fp_a", fp_a, exp_req.a);
        check("fp_b", fp_b, exp_req.b);
      end
      cap_a = fp_a;
      cap_b = fp_b;
      pend  = lat;
    end
    prev_req = fp_req;
    if (done) begin
      done_seen = 1'b1;
      check("done_cycle", 32'(cyc - start_cyc), 32'(exp_done_cyc));
      if (res_q.size() == 0) check("done_unexpected", 32'd1, 32'd0);
      else check("result", result, res_q.pop_front());
    end
  end

  task automatic expect_basic();
    req_q.push_back({32'h3FC00000, 32'hC0400000});
    req_q.push_back({32'h00000000, 32'hBFC00000});
    req_q.push_back({32'hC0300000, 32'h40000000});
    req_q.push_back({32'hBFC00000, 32'hBF400000});
    res_q.push_back(32'hC0100000);
    exp_done_cyc = 2 * N * (lat + 1) + 1;
  endtask

  task automatic load_one(input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    load_valid = 1'b1; load_a = a; load_b = b;
    check("load_ready_one", {31'b0, load_ready}, 32'd1);
    @(posedge clk); #1;
    load_valid = 1'b0;
  endtask

  task automatic load_basic();
    @(posedge clk); #1;
    load_valid = 1'b1; load_a = 32'h3FC00000; load_b = 32'hC0400000;
    check("load_ready_0", {31'b0, load_ready}, 32'd1);
    @(posedge clk); #1;
    load_a = 32'hC0300000; load_b = 32'h40000000;
    check("load_ready_1", {31'b0, load_ready}, 32'd1);
    @(posedge clk); #1;
    load_valid = 1'b0;
    check("load_ready_full", {31'b0, load_ready}, 32'd0);
  endtask

  task automatic pulse_start(input bit stray_in_issue);
    @(posedge clk); #1;
    start     = 1'b1;
    start_cyc = cyc;
    done_seen = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    if (stray_in_issue) begin
      stray_ack = 1'b1;
      check("fp_req_cycle1", {31'b0, fp_req}, 32'd1);
      @(posedge clk); #1;
      stray_ack = 1'b0;
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done_seen && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (!done_seen) check("done_timeout", 32'd0, 32'd1);
    #1;
    check("load_ready_after_done", {31'b0, load_ready}, 32'd1);
    check("busy_after_done", {31'b0, busy}, 32'd0);
    check("result_held", result, 32'hC0100000);
    check("req_q_drained", 32'(req_q.size()), 32'd0);
  endtask

  task automatic expect_idle(input string tag, input int cycles, input logic [31:0] exp_result);
    int base = req_count;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    end
    check({tag, "_no_req"}, 32'(req_count), 32'(base));
    check({tag, "_result"}, result, exp_result);
  endtask

  initial begin
    rst = 1'b1; load_valid = 1'b0; load_a = '0; load_b = '0; start = 1'b0;
    model_ack = 1'b0; stray_ack = 1'b0; fp_sum = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_fp_req", {31'b0, fp_req}, 32'd0);
    check("rst_load_ready", {31'b0, load_ready}, 32'd0);
    check("rst_result", result, 32'h0);
    check("rst_fp_a", fp_a, 32'h0);
    check("rst_fp_b", fp_b, 32'h0);
    rst = 1'b0;
    #1;
    check("load_ready_after_rst", {31'b0, load_ready}, 32'd1);

    // Basic run, adder latency 1.
    lat = 1;
    load_basic();
    expect_basic();
    pulse_start(1'b0);
    check("busy_cycle1", {31'b0, busy}, 32'd1);
    wait_done();

    // Adder latency 3.
    lat = 3;
    load_basic();
    expect_basic();
    pulse_start(1'b0);
    wait_done();

    // Start ignored with one pair loaded, then the run proceeds.
    lat = 1;
    load_one(32'h3FC00000, 32'hC0400000);
    pulse_start(1'b0);
    expect_idle("underloaded", 4, 32'hC0100000);
    load_one(32'hC0300000, 32'h40000000);
    expect_basic();
    pulse_start(1'b0);
    wait_done();

    // Load held for three pairs: the third is refused.
    @(posedge clk); #1;
    load_valid = 1'b1; load_a = 32'h3FC00000; load_b = 32'hC0400000;
    check("full_ready_0", {31'b0, load_ready}, 32'd1);
    @(posedge clk); #1;
    load_a = 32'hC0300000; load_b = 32'h40000000;
    check("full_ready_1", {31'b0, load_ready}, 32'd1);
    @(posedge clk); #1;
    load_a = 32'h3F800000; load_b = 32'h3F800000;
    check("full_ready_2", {31'b0, load_ready}, 32'd0);
    @(posedge clk); #1;
    load_valid = 1'b0;
    expect_basic();
    pulse_start(1'b0);
    wait_done();

    // Stray ack in IDLE, then in ISSUE_PAIR of a new run.
    @(posedge clk); #1;
    stray_ack = 1'b1;
    @(posedge clk); #1;
    stray_ack = 1'b0;
    expect_idle("stray_idle", 2, 32'hC0100000);
    load_basic();
    expect_basic();
    pulse_start(1'b1);
    wait_done();

    // Reset in WAIT_ACC of element 0 with the ack still in flight.
    lat = 3;
    load_basic();
    expect_basic();
    begin
      int base = req_count;
      int n    = 0;
      pulse_start(1'b0);
      while (req_count < base + 2 && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
      if (req_count < base + 2) check("acc_req_timeout", 32'd0, 32'd1);
    end
    rst = 1'b1;
    #1;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    check("midrst_fp_req", {31'b0, fp_req}, 32'd0);
    check("midrst_load_ready", {31'b0, load_ready}, 32'd0);
    req_q.delete();
    res_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("postrst_result", result, 32'h0);
    check("postrst_fp_a", fp_a, 32'h0);
    check("postrst_fp_b", fp_b, 32'h0);
    check("postrst_load_ready", {31'b0, load_ready}, 32'd1);
    expect_idle("late_ack", 4, 32'h0);
    pulse_start(1'b0);
    expect_idle("postrst_start", 3, 32'h0);
    lat = 1;
    load_basic();
    expect_basic();
    pulse_start(1'b0);
    wait_done();

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pe_pair_sum_sched.md
# pe_pair_sum_sched

Controller that shares a single external floating-point adder (the PE add datapath) to reduce two N-element IEEE-754 single-precision vectors. It computes result = sum over i of (A[i] + B[i]). Operand pairs are loaded serially into internal buffers. On start, the block issues two add requests per element to the adder: a pair-sum, then an accumulate. It sits between the operand source and the adder, and reports a done pulse with the final result.

## Interface
- N, 2: number of element pairs per run; must be ≥ 1.
- CW, $clog2(N+1): width of the index and load counters.

- clk  in  1  single clock; everything is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- load_valid  in  1  an operand pair is offered on load_a/load_b.
- load_a  in  32  A[i] in IEEE-754 single precision.
- load_b  in  32  B[i] in IEEE-754 single precision.
- load_ready  out  1  buffer can accept a pair. High only in IDLE while load_cnt < N.
- start  in  1  begin a run. Accepted only in IDLE with load_cnt == N; ignored otherwise.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when result is final.
- result  out  32  accumulated sum. Holds its value until the next accepted start.
- fp_req  out  1  one-cycle request to the adder.
- fp_a  out  32  adder operand a. Stable from fp_req until fp_ack.
- fp_b  out  32  adder operand b. Stable from fp_req until fp_ack.
- fp_ack  in  1  adder result valid. Arrives ≥ 1 cycle after fp_req.
- fp_sum  in  32  adder result, sampled when fp_ack is high.

## Operation
- States: IDLE, ISSUE_PAIR, WAIT_PAIR, ISSUE_ACC, WAIT_ACC, DONE.
- IDLE:
  - A load handshake (load_valid && load_ready) writes A/B at index load_cnt, then load_cnt increments.
  - Pairs offered while load_cnt == N are not accepted (load_ready low).
- IDLE → ISSUE_PAIR on an accepted start. The same cycle clears acc to +0.0 (32'h0000_0000) and sets idx = 0.
- ISSUE_PAIR:
  - Drives fp_req = 1, fp_a = A[idx], fp_b = B[idx].
  - Goes to WAIT_PAIR.
- WAIT_PAIR:
  - On fp_ack, latches s = fp_sum and goes to ISSUE_ACC.
- ISSUE_ACC:
  - Drives fp_req = 1, fp_a = acc, fp_b = s.
  - Goes to WAIT_ACC.
- WAIT_ACC:
  - On fp_ack, acc = fp_sum.
  - If idx == N-1, goes to DONE; otherwise idx increments and the FSM goes to ISSUE_PAIR.
- DONE:
  - result = acc, done = 1 for one cycle.
  - load_cnt is cleared to 0, so the buffers must be reloaded before the next run.
  - Goes to IDLE.
- fp_ack is ignored outside WAIT_PAIR and WAIT_ACC, including a stray ack in the same cycle as fp_req.
- The block does no arithmetic; all FP rounding and special values (NaN, Inf) come from the adder and pass through unchanged.
- Reset, including in the middle of a run:
  - state = IDLE; load_cnt, idx, acc and result are 0.
  - busy, done, fp_req and load_ready are 0 in the reset cycle.
  - fp_a and fp_b are 0.
  - An ack still in flight after reset is ignored.

## Timing
- Start is accepted at cycle 0.
- The first fp_req is at cycle 1.
- With an adder ack latency of L cycles (ack at req + L), each element takes 2(L+1) cycles.
- done pulses at cycle 2N(L+1) + 1. For N = 2, L = 1 this is cycle 9.
- busy is high from cycle 1 through the done cycle.
- load_ready returns high in the cycle after done.
- Only one add request is outstanding at a time. fp_req is never high on two consecutive cycles.
- Back-to-back loads are sustained at one pair per cycle.

## Structure
- Shared package pe_pkg holds:
  - the state enum;
  - FP_W = 32;
  - FP_ZERO = 32'h0000_0000.
- Sub-module pe_operand_buf: an N-entry A/B register buffer with one write port (index, data) and one read index. It holds no FSM logic.
- The FSM, counters, acc and s live in pe_pair_sum_sched.

## Test plan
- Basic run:
  - Stimulus: load A = {1.5, -2.75} (3FC00000, C0300000) and B = {-3.0, 2.0} (C0400000, 40000000). Start, with a bench adder model at L = 1.
  - Required: fp_req sequences (3FC00000, C0400000) → (00000000, BFC00000) → (C0300000, 40000000) → (BFC00000, BF400000). done at cycle 9 with result C0100000 (-2.25).
- Adder latency 3:
  - Stimulus: same data as the basic run.
  - Required: done at cycle 17 with the same result; fp_a/fp_b stable throughout each wait.
- Start ignored when underloaded:
  - Stimulus: start after only 1 of 2 pairs is loaded.
  - Required: busy stays 0 and no fp_req.
  - Stimulus: then load the 2nd pair and start.
  - Required: the run proceeds.
- Load refused while full:
  - Stimulus: load_valid held for 3 pairs.
  - Required: load_ready drops after the 2nd pair; the 3rd pair is not accepted.
- Reset mid-run:
  - Stimulus: assert rst in WAIT_ACC of element 0, then deliver an fp_ack after reset.
  - Required: the ack is ignored; all outputs are 0; load_cnt is 0.
- Stray ack:
  - Stimulus: pulse fp_ack in IDLE and in ISSUE_PAIR.
  - Required: no change to state, acc or result.
